// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_pkg
//  Description : Shared constants and types for the 3x3 window generator.
//                PIX_W / LINE_ADDR_W / IMG_W_MAX are the default build sizes,
//                MATRIX_LATENCY is the input-clken to window latency, and
//                pix_win_t is the 3x3 window, element k = (row-1)*3 + (col-1)
//                (element 0 = p11 = oldest line, oldest column).
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

  localparam int PIX_W          = 8;
  localparam int LINE_ADDR_W    = 11;
  localparam int IMG_W_MAX      = 1280;
  localparam int MATRIX_LATENCY = 2;

  typedef logic [8:0][PIX_W-1:0] pix_win_t;

endpackage
`default_nettype wire

// File: rtl/line_delay_ram.sv
`default_nettype none
// ============================================================================
//  Module      : line_delay_ram
//  Description : One line of delay. Simple dual-port RAM with a write and a
//                read address that both start at 0, advance on en and wrap
//                after depth-1, so a written pixel reappears on dout exactly
//                depth enables later. The read is registered (1 clk) and is
//                read-before-write at the shared address.
//  Ports       : clk, rst_n (async, active low)
//                clr   - force both addresses to 0 (takes effect this cycle)
//                en    - write din / read old entry / advance addresses
//                depth - delay length in pixels (>= 2)
//                din   - pixel in, dout - registered delayed pixel
//  Revision    : 1.0 - initial release
// ============================================================================
module line_delay_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH_W    = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DEPTH_W-1:0]    depth,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam logic [DEPTH_W-1:0] C_DEPTH_ONE = 1;

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] r_waddr, r_raddr;
  logic [ADDR_WIDTH-1:0] w_waddr, w_raddr;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [DEPTH_W-1:0]    d);
    logic [DEPTH_W-1:0] a_ext;
    a_ext = {{(DEPTH_W-ADDR_WIDTH){1'b0}}, a};
    if (a_ext == d - C_DEPTH_ONE) return '0;
    else                          return a + ADDR_WIDTH'(1);
  endfunction

  // clr overrides the stored address for this cycle's access as well
  assign w_waddr = clr ? '0 : r_waddr;
  assign w_raddr = clr ? '0 : r_raddr;

  always_ff @(posedge clk) begin
    if (en) r_mem[w_waddr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waddr <= '0;
      r_raddr <= '0;
      dout    <= '0;
    end else begin
      r_waddr <= en ? next_addr(w_waddr, depth) : w_waddr;
      r_raddr <= en ? next_addr(w_raddr, depth) : w_raddr;
      if (en) dout <= r_mem[w_raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/matrix_3x3_gen_8bit.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_3x3_gen_8bit
//  Description : Builds a registered 3x3 pixel window from a raster stream
//                using two line-delay RAMs, plus vsync/href/clken delayed by
//                2 clk so they line up with the window.
//                Optional macro MATRIX_BORDER_ZERO_EN zeroes window entries
//                that fall above the first line / left of the first column.
//  Ports       : clk, rst_n (async, active low)
//                img_width        - pixels per line, latched on vsync rise
//                per_frame_*      - input vsync / href / clken, per_img_y
//                matrix_frame_*   - controls delayed 2 clk
//                matrix_p11..p33  - window, pRC, R1 oldest line, C3 newest
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_3x3_gen_8bit
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_W,
  parameter int ADDR_WIDTH = LINE_ADDR_W,
  parameter int MAX_WIDTH  = IMG_W_MAX
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [13:0]           img_width,
  input  logic                  per_frame_vsync,
  input  logic                  per_frame_href,
  input  logic                  per_frame_clken,
  input  logic [DATA_WIDTH-1:0] per_img_y,
  output logic                  matrix_frame_vsync,
  output logic                  matrix_frame_href,
  output logic                  matrix_frame_clken,
  output logic [DATA_WIDTH-1:0] matrix_p11,
  output logic [DATA_WIDTH-1:0] matrix_p12,
  output logic [DATA_WIDTH-1:0] matrix_p13,
  output logic [DATA_WIDTH-1:0] matrix_p21,
  output logic [DATA_WIDTH-1:0] matrix_p22,
  output logic [DATA_WIDTH-1:0] matrix_p23,
  output logic [DATA_WIDTH-1:0] matrix_p31,
  output logic [DATA_WIDTH-1:0] matrix_p32,
  output logic [DATA_WIDTH-1:0] matrix_p33
);

  localparam int               C_CNT_W   = 14;
  localparam logic [C_CNT_W-1:0] C_CNT_ONE = 1;

  logic               r_vsync_d1, r_vsync_d2;
  logic               r_href_d1,  r_href_d2;
  logic               r_clken_d1, r_clken_d2;
  logic               w_vsync_rise;
  logic [C_CNT_W-1:0] r_width, w_depth, w_depth2;
  logic [DATA_WIDTH-1:0] r_row3, w_row2, w_row1;
  pix_win_t           r_win, w_win_nxt;

  assign w_vsync_rise = per_frame_vsync & ~r_vsync_d1;
  // A new width must already govern the write that coincides with vsync rise
  assign w_depth  = w_vsync_rise ? img_width : r_width;
  // Line 1's output is registered, so line 2 sees each pixel one enable late;
  // one entry less keeps the row-1 tap at exactly two lines of delay.
  assign w_depth2 = w_depth - C_CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d1 <= 1'b0;
      r_vsync_d2 <= 1'b0;
      r_href_d1  <= 1'b0;
      r_href_d2  <= 1'b0;
      r_clken_d1 <= 1'b0;
      r_clken_d2 <= 1'b0;
      r_width    <= C_CNT_W'(MAX_WIDTH);
      r_row3     <= '0;
    end else begin
      r_vsync_d1 <= per_frame_vsync;
      r_vsync_d2 <= r_vsync_d1;
      r_href_d1  <= per_frame_href;
      r_href_d2  <= r_href_d1;
      r_clken_d1 <= per_frame_clken;
      r_clken_d2 <= r_clken_d1;
      if (w_vsync_rise)    r_width <= img_width;
      if (per_frame_clken) r_row3  <= per_img_y;
    end
  end

  line_delay_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH_W    (C_CNT_W)
  ) u_line1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_vsync_rise),
    .en    (per_frame_clken),
    .depth (w_depth),
    .din   (per_img_y),
    .dout  (w_row2)
  );

  line_delay_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH_W    (C_CNT_W)
  ) u_line2 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_vsync_rise),
    .en    (per_frame_clken),
    .depth (w_depth2),
    .din   (w_row2),
    .dout  (w_row1)
  );

`ifdef MATRIX_BORDER_ZERO_EN
  // Counters run on the d1-stage controls so they describe the pixel being
  // shifted into the window this cycle.
  logic [C_CNT_W-1:0] r_line, r_col, w_line_cur, w_col_cur;

  assign w_line_cur = (r_vsync_d1 & ~r_vsync_d2) ? '0 : r_line;
  assign w_col_cur  = (r_href_d1  & ~r_href_d2)  ? '0 : r_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
      r_col  <= '0;
    end else begin
      r_line <= (r_href_d2 & ~r_href_d1 & ~&w_line_cur) ? w_line_cur + C_CNT_ONE : w_line_cur;
      r_col  <= (r_clken_d1 & ~&w_col_cur) ? w_col_cur + C_CNT_ONE : w_col_cur;
    end
  end
`endif

  // Column shift: each row moves left one place and takes its new tap at C3
  always_comb begin
    w_win_nxt = r_win;
    for (int r = 0; r < 3; r++) begin
      w_win_nxt[r*3+0] = r_win[r*3+1];
      w_win_nxt[r*3+1] = r_win[r*3+2];
    end
    w_win_nxt[2] = w_row1;
    w_win_nxt[5] = w_row2;
    w_win_nxt[8] = r_row3;
`ifdef MATRIX_BORDER_ZERO_EN
    for (int c = 0; c < 3; c++) begin
      if (w_line_cur == '0) begin
        w_win_nxt[c]   = '0;
        w_win_nxt[3+c] = '0;
      end else if (w_line_cur == C_CNT_ONE) begin
        w_win_nxt[c]   = '0;
      end
    end
    for (int r = 0; r < 3; r++) begin
      if (w_col_cur == '0) begin
        w_win_nxt[r*3+0] = '0;
        w_win_nxt[r*3+1] = '0;
      end else if (w_col_cur == C_CNT_ONE) begin
        w_win_nxt[r*3+0] = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_win <= '0;
    else if (r_clken_d1) r_win <= w_win_nxt;
  end

  assign matrix_frame_vsync = r_vsync_d2;
  assign matrix_frame_href  = r_href_d2;
  assign matrix_frame_clken = r_clken_d2;
  assign matrix_p11 = r_win[0];
  assign matrix_p12 = r_win[1];
  assign matrix_p13 = r_win[2];
  assign matrix_p21 = r_win[3];
  assign matrix_p22 = r_win[4];
  assign matrix_p23 = r_win[5];
  assign matrix_p31 = r_win[6];
  assign matrix_p32 = r_win[7];
  assign matrix_p33 = r_win[8];

endmodule
`default_nettype wire

// File: tb/tb_matrix_3x3_gen_8bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_3x3_gen_8bit
//  Description : Directed self-checking bench for matrix_3x3_gen_8bit using
//                ramp frames (pixel = 16*row + col).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_3x3_gen_8bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] img_width = 14'd4;
  logic        per_frame_vsync = 1'b0;
  logic        per_frame_href = 1'b0;
  logic        per_frame_clken = 1'b0;
  logic [7:0]  per_img_y = 8'd0;
  logic        matrix_frame_vsync, matrix_frame_href, matrix_frame_clken;
  logic [7:0]  p11, p12, p13, p21, p22, p23, p31, p32, p33;

  matrix_3x3_gen_8bit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .img_width          (img_width),
    .per_frame_vsync    (per_frame_vsync),
    .per_frame_href     (per_frame_href),
    .per_frame_clken    (per_frame_clken),
    .per_img_y          (per_img_y),
    .matrix_frame_vsync (matrix_frame_vsync),
    .matrix_frame_href  (matrix_frame_href),
    .matrix_frame_clken (matrix_frame_clken),
    .matrix_p11         (p11),
    .matrix_p12         (p12),
    .matrix_p13         (p13),
    .matrix_p21         (p21),
    .matrix_p22         (p22),
    .matrix_p23         (p23),
    .matrix_p31         (p31),
    .matrix_p32         (p32),
    .matrix_p33         (p33)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [71:0] win;
  assign win = {p11, p12, p13, p21, p22, p23, p31, p32, p33};

  int n_checks = 0;
  int n_fail   = 0;

  // Capture every output pulse with its cycle number
  logic [71:0] cap_win [0:1023];
  int          cap_cyc [0:1023];
  int          cap_total = 0;
  int          hold_err  = 0;
  logic [71:0] prev_win  = '0;
  int          in_cyc [0:255];
  int          frame_base = 0;

  always @(negedge clk) begin
    if (matrix_frame_clken) begin
      cap_win[cap_total % 1024] <= win;
      cap_cyc[cap_total % 1024] <= cyc;
      cap_total <= cap_total + 1;
    end else if (rst_n && win !== prev_win) begin
      hold_err <= hold_err + 1;
    end
    prev_win <= win;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] v;
    int rr, cc;
    v = '0;
    for (int R = 0; R < 3; R++) begin
      for (int C = 0; C < 3; C++) begin
        rr = r - 2 + R;
        cc = c - 2 + C;
        v[71-8*(3*R+C) -: 8] = (rr < 0 || cc < 0) ? 8'h00 : 8'(16*rr + cc);
      end
    end
    return v;
  endfunction

  task automatic drive_frame(input int w, input int rows, input int cols,
                             input int gap, input int w_mid, input int sync_first);
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    step(3);
    img_width       = 14'(w);
    per_frame_vsync = 1'b1;
    frame_base      = cap_total;
    if (sync_first == 0) step(2);
    for (int r = 0; r < rows; r++) begin
      per_frame_href = 1'b1;
      for (int c = 0; c < cols; c++) begin
        per_img_y       = 8'(16*r + c);
        per_frame_clken = 1'b1;
        in_cyc[r*cols + c] = cyc;
        step(1);
        per_frame_clken = 1'b0;
        if (gap > 0) step(gap);
      end
      per_frame_href = 1'b0;
      if (r == 0 && w_mid != 0) img_width = 14'(w_mid);
      step(3);
    end
    per_frame_vsync = 1'b0;
    step(4);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      per_frame_vsync = 1'($urandom_range(0, 1));
      per_frame_href  = 1'($urandom_range(0, 1));
      per_frame_clken = 1'($urandom_range(0, 1));
      per_img_y       = 8'($urandom);
      img_width       = 14'($urandom_range(2, 1280));
      step(1);
      n_checks++;
      if ({win, matrix_frame_vsync, matrix_frame_href, matrix_frame_clken} !== 75'd0) begin
        n_fail++;
        $display("FAIL reset_hold: got win=%h ctl=%b%b%b expected all 0", win,
                 matrix_frame_vsync, matrix_frame_href, matrix_frame_clken);
      end
    end
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_y       = 8'd0;
    img_width       = 14'd4;
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_checks++;
      if ({win, matrix_frame_vsync, matrix_frame_href, matrix_frame_clken} !== 75'd0) begin
        n_fail++;
        $display("FAIL reset_release: got win=%h ctl=%b%b%b expected all 0", win,
                 matrix_frame_vsync, matrix_frame_href, matrix_frame_clken);
      end
    end
  endtask

  task automatic test_ctrl_delay;
    per_frame_vsync = 1'b1;
    step(1);
    n_checks++;
    if (matrix_frame_vsync !== 1'b0) begin
      n_fail++;
      $display("FAIL vsync_d1: got %b expected 0", matrix_frame_vsync);
    end
    step(1);
    n_checks++;
    if (matrix_frame_vsync !== 1'b1) begin
      n_fail++;
      $display("FAIL vsync_d2: got %b expected 1", matrix_frame_vsync);
    end
    per_frame_vsync = 1'b0;
    step(3);
  endtask

  task automatic test_ramp;
    drive_frame(4, 3, 4, 0, 0, 0);
    n_checks++;
    if (cap_total - frame_base !== 12) begin
      n_fail++;
      $display("FAIL ramp_count: got %0d expected 12", cap_total - frame_base);
    end
    n_checks++;
    if (cap_win[(frame_base + 10) % 1024] !== exp_win(2, 2)) begin
      n_fail++;
      $display("FAIL ramp_win_2_2: got %h expected %h", cap_win[(frame_base + 10) % 1024], exp_win(2, 2));
    end
    n_checks++;
    if (cap_win[(frame_base + 11) % 1024] !== exp_win(2, 3)) begin
      n_fail++;
      $display("FAIL ramp_win_2_3: got %h expected %h", cap_win[(frame_base + 11) % 1024], exp_win(2, 3));
    end
    n_checks++;
    if (cap_cyc[(frame_base + 10) % 1024] - in_cyc[10] !== 2) begin
      n_fail++;
      $display("FAIL ramp_latency: got %0d expected 2", cap_cyc[(frame_base + 10) % 1024] - in_cyc[10]);
    end
  endtask

  task automatic test_gapped;
    int h0;
    h0 = hold_err;
    drive_frame(4, 3, 4, 2, 0, 0);
    n_checks++;
    if (cap_total - frame_base !== 12) begin
      n_fail++;
      $display("FAIL gap_count: got %0d expected 12", cap_total - frame_base);
    end
    n_checks++;
    if (cap_win[(frame_base + 10) % 1024] !== exp_win(2, 2)) begin
      n_fail++;
      $display("FAIL gap_win_2_2: got %h expected %h", cap_win[(frame_base + 10) % 1024], exp_win(2, 2));
    end
    n_checks++;
    if (cap_win[(frame_base + 11) % 1024] !== exp_win(2, 3)) begin
      n_fail++;
      $display("FAIL gap_win_2_3: got %h expected %h", cap_win[(frame_base + 11) % 1024], exp_win(2, 3));
    end
    n_checks++;
    if (cap_cyc[(frame_base + 6) % 1024] - in_cyc[6] !== 2) begin
      n_fail++;
      $display("FAIL gap_latency: got %0d expected 2", cap_cyc[(frame_base + 6) % 1024] - in_cyc[6]);
    end
    n_checks++;
    if (hold_err !== h0) begin
      n_fail++;
      $display("FAIL gap_hold: got %0d changes between pulses expected 0", hold_err - h0);
    end
  endtask

  task automatic test_width_change;
    drive_frame(4, 3, 4, 0, 6, 0);
    n_checks++;
    if (cap_win[(frame_base + 10) % 1024] !== exp_win(2, 2)) begin
      n_fail++;
      $display("FAIL wmid_win_2_2: got %h expected %h", cap_win[(frame_base + 10) % 1024], exp_win(2, 2));
    end
    n_checks++;
    if (cap_win[(frame_base + 11) % 1024] !== exp_win(2, 3)) begin
      n_fail++;
      $display("FAIL wmid_win_2_3: got %h expected %h", cap_win[(frame_base + 11) % 1024], exp_win(2, 3));
    end
    // New width applies at the next vsync rise, first pixel coincident with it
    drive_frame(6, 3, 6, 0, 0, 1);
    n_checks++;
    if (cap_total - frame_base !== 18) begin
      n_fail++;
      $display("FAIL w6_count: got %0d expected 18", cap_total - frame_base);
    end
    n_checks++;
    if (cap_win[(frame_base + 17) % 1024] !== exp_win(2, 5)) begin
      n_fail++;
      $display("FAIL w6_win_2_5: got %h expected %h", cap_win[(frame_base + 17) % 1024], exp_win(2, 5));
    end
    n_checks++;
    if (cap_win[(frame_base + 15) % 1024] !== exp_win(2, 3)) begin
      n_fail++;
      $display("FAIL w6_win_2_3: got %h expected %h", cap_win[(frame_base + 15) % 1024], exp_win(2, 3));
    end
  endtask

`ifdef MATRIX_BORDER_ZERO_EN
  task automatic test_border;
    drive_frame(4, 3, 4, 0, 0, 0);
    n_checks++;
    if (cap_win[(frame_base + 0) % 1024] !== exp_win(0, 0)) begin
      n_fail++;
      $display("FAIL border_win_0_0: got %h expected %h", cap_win[frame_base % 1024], exp_win(0, 0));
    end
    n_checks++;
    if (cap_win[(frame_base + 7) % 1024] !== exp_win(1, 3)) begin
      n_fail++;
      $display("FAIL border_win_1_3: got %h expected %h", cap_win[(frame_base + 7) % 1024], exp_win(1, 3));
    end
    n_checks++;
    if (cap_win[(frame_base + 8) % 1024] !== exp_win(2, 0)) begin
      n_fail++;
      $display("FAIL border_win_2_0: got %h expected %h", cap_win[(frame_base + 8) % 1024], exp_win(2, 0));
    end
    n_checks++;
    if (cap_win[(frame_base + 9) % 1024] !== exp_win(2, 1)) begin
      n_fail++;
      $display("FAIL border_win_2_1: got %h expected %h", cap_win[(frame_base + 9) % 1024], exp_win(2, 1));
    end
  endtask
`endif

  task automatic test_async_reset;
    per_frame_vsync = 1'b0;
    step(3);
    img_width       = 14'd4;
    per_frame_vsync = 1'b1;
    step(2);
    for (int r = 0; r < 2; r++) begin
      per_frame_href = 1'b1;
      for (int c = 0; c < ((r == 0) ? 4 : 2); c++) begin
        per_img_y       = 8'(16*r + c);
        per_frame_clken = 1'b1;
        step(1);
        per_frame_clken = 1'b0;
      end
      if (r == 0) begin
        per_frame_href = 1'b0;
        step(3);
      end
    end
    step(2);
    n_checks++;
    if (p33 !== 8'h11) begin
      n_fail++;
      $display("FAIL areset_pre_p33: got %h expected 11", p33);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({win, matrix_frame_vsync, matrix_frame_href, matrix_frame_clken} !== 75'd0) begin
      n_fail++;
      $display("FAIL areset_immediate: got win=%h ctl=%b%b%b expected all 0", win,
               matrix_frame_vsync, matrix_frame_href, matrix_frame_clken);
    end
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    drive_frame(4, 3, 4, 0, 0, 0);
    n_checks++;
    if (cap_total - frame_base !== 12) begin
      n_fail++;
      $display("FAIL areset_count: got %0d expected 12", cap_total - frame_base);
    end
    n_checks++;
    if (cap_win[(frame_base + 10) % 1024] !== exp_win(2, 2)) begin
      n_fail++;
      $display("FAIL areset_win_2_2: got %h expected %h", cap_win[(frame_base + 10) % 1024], exp_win(2, 2));
    end
    n_checks++;
    if (cap_win[(frame_base + 11) % 1024] !== exp_win(2, 3)) begin
      n_fail++;
      $display("FAIL areset_win_2_3: got %h expected %h", cap_win[(frame_base + 11) % 1024], exp_win(2, 3));
    end
  endtask

  initial begin
    test_reset();
    test_ctrl_delay();
    test_ramp();
    test_gapped();
    test_width_change();
`ifdef MATRIX_BORDER_ZERO_EN
    test_border();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_3x3_gen_8bit.md
Name: matrix_3x3_gen_8bit

Overview:
Consumer end of the line-shift buffering path. It takes the raster pixel stream, delays it by one and two lines through internal line-delay RAMs, and taps those delayed lines into a registered 3x3 pixel window. It also emits frame/line/pixel-valid controls aligned with the window. It sits between the sensor/scaler stream and the 3x3 filters (Sobel, median, erode/dilate).

Parameters:
DATA_WIDTH, 8, pixel width
ADDR_WIDTH, 11, line-RAM address width; max line = 2**ADDR_WIDTH
MAX_WIDTH, 1280, largest supported img_width

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
img_width  in  14  active pixels per line; sampled on per_frame_vsync rising edge
per_frame_vsync  in  1  frame sync, high during frame
per_frame_href  in  1  line valid
per_frame_clken  in  1  pixel valid (may gap within href)
per_img_y  in  DATA_WIDTH  input pixel
matrix_frame_vsync  out  1  vsync delayed 2 clk
matrix_frame_href  out  1  href delayed 2 clk
matrix_frame_clken  out  1  clken delayed 2 clk
matrix_p11..matrix_p33  out  DATA_WIDTH each  window; pRC, R1 = oldest line, C3 = newest column

Behaviour:
- One clock (clk); rst_n is asynchronous and active-low; all flops clear on reset.
- Reset values: all outputs 0. Address counters 0. Line/column counters 0. Latched width = MAX_WIDTH.
- Width latch: on vsync 0->1, width_q <= img_width. A mid-frame change of img_width is ignored until the next frame.
- Line delay 1: writes per_img_y at waddr on per_frame_clken and reads raddr the same cycle. Read data is registered, giving 1 clk latency.
  - Both addresses start at 0 and advance only on clken.
  - Wrap: address == width_q-1 -> 0. The range is exactly 0..width_q-1, so the delay is exactly width_q pixels.
  - Read-before-write at the same address returns the old data.
- Line delay 2 is fed by line delay 1's output, written on the same clken. Total delay is 2*width_q pixels.
- Row3 tap = per_img_y registered once. Row2 = line delay 1 output. Row1 = line delay 2 output. All three are aligned at clk+1.
- Column shift: on clken_d1, for each row, pR1 <= pR2, pR2 <= pR3, pR3 <= row tap. Outputs update at clk+2 relative to the input clken. Without clken_d1, outputs hold.
- Controls: vsync/href/clken each pass through 2 flops. Window and matrix_frame_clken are coincident.
- Line counter: cleared on vsync rising edge; increments on each href falling edge; saturates at 2**14-1.
- Column counter: cleared on href rising edge; increments on each clken_d1.
- Reset mid-frame clears everything. The first frame after reset produces a stale or zero window until two full lines have passed.
- Simultaneous vsync rise and clken: the width latch takes effect before the first write. Address counters are also forced to 0 on vsync rise.

Optional Feature:
- Macro MATRIX_BORDER_ZERO_EN.
- Defined:
  - Line counter 0 -> rows 1,2 forced 0.
  - Line counter 1 -> row 1 forced 0.
  - Column counter 0 -> columns 1,2 forced 0.
  - Column counter 1 -> column 1 forced 0.
  - Masking is applied in the output register stage, so latency is unchanged.
- Undefined: the window outputs raw shift contents (previous-line/previous-frame data at borders). No counters are synthesized.

Decomposition:
- Shared package matrix_pkg holds:
  - PIX_W = 8
  - LINE_ADDR_W = 11
  - IMG_W_MAX = 1280
  - MATRIX_LATENCY = 2
  - the window typedef pix_win_t (9 x PIX_W)
- One sub-module, line_delay_ram: simple dual-port inferred RAM with 2**ADDR_WIDTH entries, wrapping address counters, a depth input, and a registered read. It is instantiated twice.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release -> outputs stay 0 until the first clken+2.
- Ramp, width=4, pixel = 16*row+col, continuous clken: at input (row 2, col 2), two clk later p33=0x22, p32=0x21, p23=0x12, p11=0x00, matrix_frame_clken=1.
- Gapped clken, 1-of-3 pattern, same ramp: window values identical to the continuous run. Outputs hold between pulses.
- Width change: img_width 4->6 mid-frame has no effect (row-2 taps still width 4). At the next vsync rise, width 6 applies: at (row 2, col 5), p35=0x25-style taps, i.e. p33=0x25, p23=0x15.
- MATRIX_BORDER_ZERO_EN: ramp with width=4 -> at (row 0, col 0) all window entries 0 except p33=0x00 source; at (row 1, col 3), p1x=0 and p23=0x03.
- Async reset asserted mid-line 1: outputs go 0 immediately without a clock edge. Re-run frame -> results match the clean-start run.
